// File: rtl/cp0_unit_pkg.sv
// Coprocessor-0 shared definitions: register numbers,
// exception codes and the writable-field mask of SR.
package cp0_unit_pkg;

    localparam int unsigned HWINT_W = 6;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;

    // Handler entry; the NPC consumes it, not this block.
    localparam logic [31:0] HANDLER = 32'h0000_4180;

    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

    // IM[15:10], EXL[1], IE[0]
    localparam logic [31:0] SR_MASK = 32'h0000_FC03;

    function automatic logic [31:0] sr_mask(input logic [31:0] v);
        return v & SR_MASK;
    endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// Pipeline <-> CP0 bundle: mfc0/mtc0 access, victim info,
// interrupt lines and the flush request back to the pipeline.
interface cp0_unit_if;
    import cp0_unit_pkg::*;

    logic [4:0]         A1;
    logic [4:0]         A2;
    logic [31:0]        Din;
    logic               en;
    logic [31:0]        VPC;
    logic               BDIn;
    logic [4:0]         ExcCodeIn;
    logic [HWINT_W-1:0] HWInt;
    logic               EXLClr;
    logic [31:0]        Dout;
    logic [31:0]        EPCOut;
    logic               Req;

    modport master (
        output A1, A2, Din, en, VPC, BDIn,
        output ExcCodeIn, HWInt, EXLClr,
        input  Dout, EPCOut, Req
    );

    modport slave (
        input  A1, A2, Din, en, VPC, BDIn,
        input  ExcCodeIn, HWInt, EXLClr,
        output Dout, EPCOut, Req
    );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor-0: SR/Cause/EPC, interrupt vs exception
// arbitration, mfc0/mtc0/eret service.
module cp0_unit
    import cp0_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    cp0_unit_if.slave   bus
);

    logic [31:0] sr_q, sr_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;

    logic               exl;
    logic               ie;
    logic [HWINT_W-1:0] im;
    logic               int_req;
    logic               exc_req;
    logic               req;

    // Request arbitration: interrupts and exceptions blocked under EXL.
    always_comb begin
        im      = sr_q[15:10];
        exl     = sr_q[1];
        ie      = sr_q[0];
        int_req = (|(bus.HWInt & im)) & ie & ~exl;
        exc_req = (bus.ExcCodeIn != 5'd0) & ~exl;
        req     = int_req | exc_req;
    end

    // Next-state: exception entry beats mtc0; EXLClr beats mtc0 on EXL.
    always_comb begin
        sr_d    = sr_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        cause_d[15:10] = bus.HWInt;
        if (req) begin
            sr_d[1]       = 1'b1;
            cause_d[31]   = bus.BDIn;
            cause_d[6:2]  = int_req ? EXC_INT : bus.ExcCodeIn;
            epc_d         = bus.BDIn ? bus.VPC - 32'd4 : bus.VPC;
        end else begin
            if (bus.en && bus.A2 == CP0_SR)
                sr_d = sr_mask(bus.Din);
            if (bus.en && bus.A2 == CP0_EPC)
                epc_d = bus.Din;
            if (bus.EXLClr)
                sr_d[1] = 1'b0;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q    <= '0;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            sr_q    <= sr_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    // mfc0 read mux and live outputs; reads see pre-edge state.
    always_comb begin
        bus.Dout   = '0;
        bus.EPCOut = epc_q;
        bus.Req    = req;
        case (bus.A1)
            CP0_SR:    bus.Dout = sr_q;
            CP0_CAUSE: bus.Dout = cause_q;
            CP0_EPC:   bus.Dout = epc_q;
            default:   bus.Dout = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit.
// Linear stimulus; immediate assertions at each check.
module tb_cp0_unit;
    import cp0_unit_pkg::*;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    cp0_unit_if bus ();

    cp0_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic rd(input string tag,
                      input logic [4:0] a,
                      input logic [31:0] exp);
        bus.A1 = a;
        #1;
        chk(tag, bus.Dout, exp);
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b0;
        bus.A1 = '0; bus.A2 = '0; bus.Din = '0; bus.en = 1'b0;
        bus.VPC = '0; bus.BDIn = 1'b0; bus.ExcCodeIn = '0;
        bus.HWInt = '0; bus.EXLClr = 1'b0;

        // Reset state
        repeat (2) edge_step();
        rd("rst_sr", CP0_SR, 32'h0);
        rd("rst_cause", CP0_CAUSE, 32'h0);
        rd("rst_epc", CP0_EPC, 32'h0);
        chk("rst_epcout", bus.EPCOut, 32'h0);
        chk("rst_req", {31'b0, bus.Req}, 32'h0);

        reset = 1'b1;
        edge_step();

        // mtc0 SR
        bus.en = 1'b1; bus.A2 = CP0_SR; bus.Din = 32'h0000_FC01;
        edge_step();
        bus.en = 1'b0;
        rd("sr_write", CP0_SR, 32'h0000_FC01);

        // Interrupt on line 2
        bus.HWInt = 6'b000100; bus.VPC = 32'h0000_1000;
        #1;
        chk("int_req", {31'b0, bus.Req}, 32'h1);
        edge_step();
        rd("int_cause", CP0_CAUSE, 32'h0000_1000);
        rd("int_sr_exl", CP0_SR, 32'h0000_FC03);
        chk("int_epc", bus.EPCOut, 32'h0000_1000);

        // EXL blocks nesting
        bus.ExcCodeIn = EXC_ADEL;
        #1;
        chk("exl_block", {31'b0, bus.Req}, 32'h0);

        // eret
        bus.EXLClr = 1'b1;
        edge_step();
        bus.EXLClr = 1'b0;
        rd("eret_sr", CP0_SR, 32'h0000_FC01);
        chk("eret_req", {31'b0, bus.Req}, 32'h1);

        // Interrupt beats exception; concurrent mtc0 EPC dropped
        bus.ExcCodeIn = EXC_RI; bus.VPC = 32'h0000_2000;
        bus.en = 1'b1; bus.A2 = CP0_EPC; bus.Din = 32'hDEAD_BEEF;
        edge_step();
        bus.en = 1'b0;
        rd("prio_cause", CP0_CAUSE, 32'h0000_1000);
        chk("prio_epc", bus.EPCOut, 32'h0000_2000);

        // Leave handler, quiet lines
        bus.HWInt = '0; bus.ExcCodeIn = '0; bus.EXLClr = 1'b1;
        edge_step();
        bus.EXLClr = 1'b0;
        rd("clr_cause", CP0_CAUSE, 32'h0);

        // Overflow in delay slot
        bus.ExcCodeIn = EXC_OV; bus.VPC = 32'h0000_3008; bus.BDIn = 1'b1;
        #1;
        chk("ov_req", {31'b0, bus.Req}, 32'h1);
        edge_step();
        bus.ExcCodeIn = '0; bus.BDIn = 1'b0;
        chk("ov_epc", bus.EPCOut, 32'h0000_3004);
        rd("ov_cause", CP0_CAUSE, 32'h8000_0030);

        // Cause is read-only
        bus.en = 1'b1; bus.A2 = CP0_CAUSE; bus.Din = 32'hFFFF_FFFF;
        edge_step();
        bus.en = 1'b0;
        rd("cause_ro", CP0_CAUSE, 32'h8000_0030);
        rd("rd_other", 5'd7, 32'h0);

        // EXLClr with mtc0 SR: EXL cleared, rest written masked
        bus.en = 1'b1; bus.A2 = CP0_SR; bus.Din = 32'hFFFF_FFFF;
        bus.EXLClr = 1'b1;
        edge_step();
        bus.EXLClr = 1'b0;
        bus.A2 = CP0_EPC; bus.Din = 32'h1234_5678;
        rd("sr_exlclr", CP0_SR, 32'h0000_FC01);
        edge_step();
        bus.en = 1'b0;
        chk("epc_write", bus.EPCOut, 32'h1234_5678);

        // EPC wrap below zero
        bus.ExcCodeIn = EXC_ADES; bus.VPC = 32'h0; bus.BDIn = 1'b1;
        edge_step();
        bus.ExcCodeIn = '0; bus.BDIn = 1'b0;
        chk("epc_wrap", bus.EPCOut, 32'hFFFF_FFFC);
        rd("wrap_cause", CP0_CAUSE, 32'h8000_0014);

        // Async reset mid-handler
        #2;
        reset = 1'b0;
        #1;
        rd("mid_rst_sr", CP0_SR, 32'h0);
        rd("mid_rst_cause", CP0_CAUSE, 32'h0);
        chk("mid_rst_epc", bus.EPCOut, 32'h0);
        chk("mid_rst_req", {31'b0, bus.Req}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
